// File: rtl/reg_access_seq_if.sv
// rtl/reg_access_seq_if.sv - decode/execute/register-bank signal bundle for reg_access_seq
interface reg_access_seq_if;

  // Single-port register bank request: mode=1 writes data into register sel
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  sel;
    logic        mode;
  } reg_in_bus_t;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  a_sel;
  logic [2:0]  b_sel;
  logic [2:0]  c_sel;
  logic        rd_b;
  logic        rd_c;
  logic        wr_a;
  reg_in_bus_t out_bus;
  logic [31:0] q;
  logic        opnd_valid;
  logic        opnd_ready;
  logic [31:0] b_val;
  logic [31:0] c_val;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        done;
  logic        busy;

  // Sequencer side
  modport master (
    input  req_valid, a_sel, b_sel, c_sel, rd_b, rd_c, wr_a, q,
    input  opnd_ready, res_valid, res_data,
    output req_ready, out_bus, opnd_valid, b_val, c_val, res_ready, done, busy
  );

  // Decode / execute / bank side
  modport slave (
    output req_valid, a_sel, b_sel, c_sel, rd_b, rd_c, wr_a, q,
    output opnd_ready, res_valid, res_data,
    input  req_ready, out_bus, opnd_valid, b_val, c_val, res_ready, done, busy
  );

endinterface

// File: rtl/reg_access_seq.sv
// rtl/reg_access_seq.sv - sequences read B, read C, operand hand-off and write-back of A through one bank port
module reg_access_seq #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  reg_access_seq_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_B = 3'd1,
    RD_C = 3'd2,
    OPND = 3'd3,
    RES  = 3'd4,
    WR_A = 3'd5
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  a_sel_q, a_sel_d;
  logic [2:0]  b_sel_q, b_sel_d;
  logic [2:0]  c_sel_q, c_sel_d;
  logic        rd_c_q, rd_c_d;
  logic        wr_a_q, wr_a_d;
  logic [31:0] res_q, res_d;
  logic [31:0] b_val_q, b_val_d;
  logic [31:0] c_val_q, c_val_d;
  logic        done_q, done_d;

  // Next-state, captured data and all outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sel_d  = a_sel_q;
    b_sel_d  = b_sel_q;
    c_sel_d  = c_sel_q;
    rd_c_d   = rd_c_q;
    wr_a_d   = wr_a_q;
    res_d    = res_q;
    b_val_d  = b_val_q;
    c_val_d  = c_val_q;
    done_d   = 1'b0;

    bus.out_bus    = '0;
    bus.req_ready  = 1'b0;
    bus.opnd_valid = 1'b0;
    bus.res_ready  = 1'b0;
    bus.done       = done_q;
    bus.busy       = (state_q != IDLE);
    bus.b_val      = b_val_q;
    bus.c_val      = c_val_q;

    case (state_q)
      IDLE: begin
        // The done cycle after a write-back is spent in IDLE; keep it closed to new requests
        bus.req_ready = !done_q;
        if (bus.req_valid && !done_q) begin
          a_sel_d = bus.a_sel;
          b_sel_d = bus.b_sel;
          c_sel_d = bus.c_sel;
          rd_c_d  = bus.rd_c;
          wr_a_d  = bus.wr_a;
          b_val_d = '0;
          c_val_d = '0;
          cnt_d   = '0;
          if (bus.rd_b)      state_d = RD_B;
          else if (bus.rd_c) state_d = RD_C;
          else               state_d = OPND;
        end
      end
      RD_B: begin
        bus.out_bus.sel = b_sel_q;
        if (cnt_q == LAT) begin
          b_val_d = bus.q;
          cnt_d   = '0;
          state_d = rd_c_q ? RD_C : OPND;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RD_C: begin
        bus.out_bus.sel = c_sel_q;
        if (cnt_q == LAT) begin
          c_val_d = bus.q;
          cnt_d   = '0;
          state_d = OPND;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      OPND: begin
        bus.opnd_valid = 1'b1;
        if (bus.opnd_ready) begin
          if (wr_a_q) begin
            state_d = RES;
          end else begin
            bus.done = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      RES: begin
        bus.res_ready = 1'b1;
        if (bus.res_valid) begin
          res_d   = bus.res_data;
          state_d = WR_A;
        end
      end
      WR_A: begin
        // A reset arriving in the write cycle cancels the beat rather than letting the bank commit it
        if (!reset) begin
          bus.out_bus.mode = 1'b1;
          bus.out_bus.sel  = a_sel_q;
          bus.out_bus.data = res_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sel_q <= '0;
      b_sel_q <= '0;
      c_sel_q <= '0;
      rd_c_q  <= 1'b0;
      wr_a_q  <= 1'b0;
      res_q   <= '0;
      b_val_q <= '0;
      c_val_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
      c_sel_q <= c_sel_d;
      rd_c_q  <= rd_c_d;
      wr_a_q  <= wr_a_d;
      res_q   <= res_d;
      b_val_q <= b_val_d;
      c_val_q <= c_val_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_access_seq.sv
// tb/tb_reg_access_seq.sv - self-checking bench for reg_access_seq (READ_LAT=1 and READ_LAT=3 instances)
module tb_reg_access_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_access_seq_if bus1 ();
  reg_access_seq_if bus3 ();

  reg_access_seq #(.READ_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  reg_access_seq #(.READ_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Register bank model for dut1: q shows the register selected one cycle earlier
  logic [31:0] regs [8];
  logic [2:0]  sel_d1 = '0;
  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  int          beat_cnt = 0;
  int          beat_cnt3 = 0;
  int          cyc_cnt = 0;

  always @(posedge clk) begin
    if (pre_en) regs[pre_idx] <= pre_data;
    else if (bus1.out_bus.mode) begin
      regs[bus1.out_bus.sel] <= bus1.out_bus.data;
      beat_cnt <= beat_cnt + 1;
    end
    if (bus3.out_bus.mode) beat_cnt3 <= beat_cnt3 + 1;
    sel_d1  <= bus1.out_bus.sel;
    cyc_cnt <= cyc_cnt + 1;
  end

  assign bus1.q = regs[sel_d1];
  // dut3 sees a value that changes every cycle, so the capture cycle is visible in the result
  assign bus3.q = 32'hC000_0000 | 32'(cyc_cnt);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd_b, rd_c, wr_a;
    logic [2:0]  a, b, c;
    logic [31:0] res;
    int          opnd_stall, res_stall;
    logic [31:0] exp_b, exp_c;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] pre_vals [8];
  logic [63:0] opnd_q [$];
  logic [34:0] wr_q [$];

  task automatic drive_idle1();
    bus1.req_valid = 0; bus1.a_sel = 0; bus1.b_sel = 0; bus1.c_sel = 0;
    bus1.rd_b = 0; bus1.rd_c = 0; bus1.wr_a = 0;
    bus1.opnd_ready = 0; bus1.res_valid = 0; bus1.res_data = 0;
  endtask

  // One full request on dut1 with cycle-accurate checks against the table record
  task automatic run_txn(input vec_t v);
    int cyc, exp_lat, beats0, guard;
    logic [63:0] eo;
    logic [34:0] ew;
    exp_lat = (v.rd_b ? 2 : 0) + (v.rd_c ? 2 : 0) + 1;
    beats0 = beat_cnt;
    @(negedge clk);
    check("req_ready_idle", bus1.req_ready, 1);
    bus1.req_valid = 1; bus1.a_sel = v.a; bus1.b_sel = v.b; bus1.c_sel = v.c;
    bus1.rd_b = v.rd_b; bus1.rd_c = v.rd_c; bus1.wr_a = v.wr_a;
    bus1.opnd_ready = (v.opnd_stall == 0);
    bus1.res_valid  = (v.res_stall == 0);
    bus1.res_data   = v.res;
    opnd_q.push_back({v.exp_b, v.exp_c});
    if (v.wr_a) wr_q.push_back({v.a, v.res});
    @(negedge clk); cyc = 1;
    // request fields change after accept and must be ignored
    bus1.req_valid = 0; bus1.a_sel = ~v.a; bus1.b_sel = ~v.b; bus1.c_sel = ~v.c;
    bus1.rd_b = ~v.rd_b; bus1.rd_c = ~v.rd_c; bus1.wr_a = ~v.wr_a;
    guard = 0;
    while (!bus1.opnd_valid && guard < 40) begin
      check("read_mode0", bus1.out_bus.mode, 0);
      @(negedge clk); cyc++; guard++;
    end
    check("opnd_latency", cyc, exp_lat);
    for (int i = 0; i < v.opnd_stall; i++) begin
      check("stall_opnd_valid", bus1.opnd_valid, 1);
      check("stall_b_val", bus1.b_val, v.exp_b);
      check("stall_c_val", bus1.c_val, v.exp_c);
      check("stall_bus_idle", {28'b0, bus1.out_bus}, 0);
      @(negedge clk); cyc++;
    end
    bus1.opnd_ready = 1;
    eo = opnd_q.pop_front();
    check("opnd_valid", bus1.opnd_valid, 1);
    check("b_val", bus1.b_val, eo[63:32]);
    check("c_val", bus1.c_val, eo[31:0]);
    if (!v.wr_a) begin
      check("done_on_opnd", bus1.done, 1);
      @(negedge clk);
      bus1.opnd_ready = 0;
      check("done_clear", bus1.done, 0);
      check("req_ready_after", bus1.req_ready, 1);
      check("no_write_beat", beat_cnt, beats0);
    end else begin
      check("no_done_in_opnd", bus1.done, 0);
      @(negedge clk); cyc++;
      bus1.opnd_ready = 0;
      for (int i = 0; i < v.res_stall; i++) begin
        check("res_ready_wait", bus1.res_ready, 1);
        check("res_wait_bus_idle", {28'b0, bus1.out_bus}, 0);
        @(negedge clk); cyc++;
      end
      bus1.res_valid = 1;
      check("res_ready", bus1.res_ready, 1);
      @(negedge clk); cyc++;
      bus1.res_valid = 0; bus1.res_data = 32'h0BAD_0BAD;
      ew = wr_q.pop_front();
      check("wr_mode", bus1.out_bus.mode, 1);
      check("wr_sel", bus1.out_bus.sel, ew[34:32]);
      check("wr_data", bus1.out_bus.data, ew[31:0]);
      check("wr_cycle", cyc, exp_lat + v.opnd_stall + v.res_stall + 2);
      @(negedge clk); cyc++;
      check("done_after_wr", bus1.done, 1);
      check("req_ready_during_done", bus1.req_ready, 0);
      check("busy_during_done", bus1.busy, 0);
      check("bus_idle_during_done", {28'b0, bus1.out_bus}, 0);
      @(negedge clk);
      check("done_clear_wr", bus1.done, 0);
      check("req_ready_after_wr", bus1.req_ready, 1);
      check("one_write_beat", beat_cnt, beats0 + 1);
    end
    bus1.res_valid = 0;
  endtask

  initial begin
    int beats0;
    logic [31:0] exp_b3, exp_c3;

    //                rd_b rd_c wr_a a     b     c     res            os rs exp_b          exp_c
    vecs[0] = '{1'b1, 1'b1, 1'b1, 3'd7, 3'd2, 3'd5, 32'hDEAD_BEEF, 0, 0, 32'h0000_00AA, 32'h1234_5678};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 3'd7, 3'd2, 3'd5, 32'h0,         0, 0, 32'h0,         32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 3'd7, 32'h0,         0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 3'd4, 3'd3, 3'd1, 32'h4444_CAFE, 4, 3, 32'h3333_0003, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 32'h0102_0304, 0, 0, 32'h0,         32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 3'd0, 32'h0,         0, 0, 32'h4444_CAFE, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd1, 32'h0,         0, 0, 32'h0,         32'h0102_0304};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd6, 3'd2, 32'h0,         0, 0, 32'h6666_6666, 32'h0000_00AA};
    pre_vals = '{32'hBAD0_0000, 32'h1111_1111, 32'h0000_00AA, 32'h3333_0003,
                 32'h0000_0044, 32'h1234_5678, 32'h6666_6666, 32'h0000_0077};

    reset = 1;
    drive_idle1();
    bus3.req_valid = 0; bus3.a_sel = 0; bus3.b_sel = 0; bus3.c_sel = 0;
    bus3.rd_b = 0; bus3.rd_c = 0; bus3.wr_a = 0;
    bus3.opnd_ready = 0; bus3.res_valid = 0; bus3.res_data = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pre_en = 1; pre_idx = 3'(i); pre_data = pre_vals[i];
    end
    @(negedge clk);
    pre_en = 0;
    check("rst_busy", bus1.busy, 0);
    check("rst_bus", {28'b0, bus1.out_bus}, 0);
    reset = 0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_bus", {28'b0, bus1.out_bus}, 0);
      check("idle_req_ready", bus1.req_ready, 1);
      check("idle_busy", bus1.busy, 0);
      check("idle_done", bus1.done, 0);
      check("idle_opnd_valid", bus1.opnd_valid, 0);
      check("idle_res_ready", bus1.res_ready, 0);
      check("idle_bus3", {28'b0, bus3.out_bus}, 0);
      check("idle_req_ready3", bus3.req_ready, 1);
    end

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset while waiting in RES: no write beat, register 6 keeps its value
    beats0 = beat_cnt;
    @(negedge clk);
    bus1.req_valid = 1; bus1.a_sel = 3'd6; bus1.rd_b = 0; bus1.rd_c = 0; bus1.wr_a = 1;
    bus1.opnd_ready = 1; bus1.res_valid = 0; bus1.res_data = 32'hFFFF_0000;
    @(negedge clk);
    bus1.req_valid = 0;
    check("rr_opnd", bus1.opnd_valid, 1);
    @(negedge clk);
    check("rr_in_res", bus1.res_ready, 1);
    reset = 1; bus1.res_valid = 1;
    @(negedge clk);
    check("rr_busy", bus1.busy, 0);
    check("rr_res_ready", bus1.res_ready, 0);
    check("rr_opnd_valid", bus1.opnd_valid, 0);
    check("rr_done", bus1.done, 0);
    check("rr_bus", {28'b0, bus1.out_bus}, 0);
    check("rr_b_val", bus1.b_val, 0);
    reset = 0; bus1.res_valid = 0; bus1.opnd_ready = 0;
    repeat (3) begin
      @(negedge clk);
      check("rr_no_beat", beat_cnt, beats0);
    end
    run_txn('{1'b1, 1'b0, 1'b0, 3'd0, 3'd6, 3'd0, 32'h0, 0, 0, 32'h6666_6666, 32'h0});

    // READ_LAT=3: each read holds sel for 4 cycles and captures q from the 4th
    @(negedge clk);
    bus3.req_valid = 1; bus3.b_sel = 3'd3; bus3.c_sel = 3'd6;
    bus3.rd_b = 1; bus3.rd_c = 1; bus3.wr_a = 0; bus3.opnd_ready = 1;
    exp_b3 = 0; exp_c3 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus3.req_valid = 0;
      check("l3_sel", bus3.out_bus.sel, (k <= 4) ? 3'd3 : 3'd6);
      check("l3_mode", bus3.out_bus.mode, 0);
      check("l3_not_yet", bus3.opnd_valid, 0);
      if (k == 4) exp_b3 = 32'hC000_0000 | 32'(cyc_cnt);
      if (k == 8) exp_c3 = 32'hC000_0000 | 32'(cyc_cnt);
    end
    opnd_q.push_back({exp_b3, exp_c3});
    @(negedge clk);
    begin
      logic [63:0] eo;
      eo = opnd_q.pop_front();
      check("l3_opnd_valid", bus3.opnd_valid, 1);
      check("l3_b_val", bus3.b_val, eo[63:32]);
      check("l3_c_val", bus3.c_val, eo[31:0]);
      check("l3_done", bus3.done, 1);
    end
    @(negedge clk);
    bus3.opnd_ready = 0;
    check("l3_idle", bus3.req_ready, 1);
    check("l3_no_beat", beat_cnt3, 0);
    check("queues_empty", opnd_q.size() + wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
